// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the IF/MEM requesters and the unified memory.
// The slave view is the arbiter's. The master view is the requesters and memory seen as one environment.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Instruction-fetch port
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic [DATA_W-1:0] IRData;
    logic              IDone;

    // Load/store port
    logic              DRead;
    logic              DWrite;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic [BE_W-1:0]   DByteEn;
    logic [DATA_W-1:0] DRData;
    logic              DDone;

    // Memory port
    logic              MReq;
    logic              MWrite;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MWData;
    logic [BE_W-1:0]   MByteEn;
    logic [DATA_W-1:0] MRData;
    logic              MAck;

    // Status
    logic              Err;
    logic              nStall;

    modport slave (
        input  IReq, IAddr, DRead, DWrite, DAddr, DWData, DByteEn, MRData, MAck,
        output IRData, IDone, DRData, DDone, MReq, MWrite, MAddr, MWData, MByteEn,
               Err, nStall
    );

    modport master (
        output IReq, IAddr, DRead, DWrite, DAddr, DWData, DByteEn, MRData, MAck,
        input  IRData, IDone, DRData, DDone, MReq, MWrite, MAddr, MWData, MByteEn,
               Err, nStall
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the IF and MEM pipeline requesters onto one single-ported memory.
// Data has priority, with an anti-starvation counter and a watchdog on the memory handshake.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input logic            Clock,
    input logic            nReset,
    mem_arbiter_if.slave   bus
);
    localparam int BE_W = DATA_W / 8;
    localparam int SW   = $clog2(STARVE_MAX + 1);
    localparam int TW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IBUSY = 2'd1;
    localparam logic [1:0] S_DBUSY = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic              gnt_d_q,   gnt_d_d;
    logic [SW-1:0]     starve_q,  starve_d;
    logic [TW-1:0]     tmo_q,     tmo_d;
    logic              mreq_q,    mreq_d;
    logic              mwrite_q,  mwrite_d;
    logic [ADDR_W-1:0] maddr_q,   maddr_d;
    logic [DATA_W-1:0] mwdata_q,  mwdata_d;
    logic [BE_W-1:0]   mbyteen_q, mbyteen_d;
    logic [DATA_W-1:0] irdata_q,  irdata_d;
    logic [DATA_W-1:0] drdata_q,  drdata_d;
    logic              idone_q,   idone_d;
    logic              ddone_q,   ddone_d;
    logic              err_q,     err_d;

    logic d_req;
    logic starved;

    assign d_req   = bus.DRead | bus.DWrite;
    assign starved = bus.IReq && (starve_q == SW'(STARVE_MAX));

    always_comb begin
        state_d   = state_q;
        gnt_d_d   = gnt_d_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        mreq_d    = mreq_q;
        mwrite_d  = mwrite_q;
        maddr_d   = maddr_q;
        mwdata_d  = mwdata_q;
        mbyteen_d = mbyteen_q;
        irdata_d  = irdata_q;
        drdata_d  = drdata_q;
        idone_d   = 1'b0;
        ddone_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (d_req && !starved) begin
                    state_d   = S_DBUSY;
                    gnt_d_d   = 1'b1;
                    mreq_d    = 1'b1;
                    mwrite_d  = bus.DWrite;
                    maddr_d   = bus.DAddr;
                    mwdata_d  = bus.DWData;
                    mbyteen_d = bus.DWrite ? bus.DByteEn : '1;
                    tmo_d     = '0;
                    // Count consecutive data wins only while a fetch is being held off
                    if (bus.IReq) begin
                        if (starve_q != SW'(STARVE_MAX))
                            starve_d = starve_q + 1'b1;
                    end else begin
                        starve_d = '0;
                    end
                end else if (bus.IReq) begin
                    state_d   = S_IBUSY;
                    gnt_d_d   = 1'b0;
                    mreq_d    = 1'b1;
                    mwrite_d  = 1'b0;
                    maddr_d   = bus.IAddr;
                    mwdata_d  = '0;
                    mbyteen_d = '1;
                    tmo_d     = '0;
                    starve_d  = '0;
                end
            end

            S_IBUSY, S_DBUSY: begin
                if (bus.MAck) begin
                    state_d = S_RESP;
                    mreq_d  = 1'b0;
                    if (gnt_d_q) begin
                        ddone_d = 1'b1;
                        if (!mwrite_q)
                            drdata_d = bus.MRData;
                    end else begin
                        idone_d  = 1'b1;
                        irdata_d = bus.MRData;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    // Abort: complete the access with Err and zeroed read data
                    state_d = S_RESP;
                    mreq_d  = 1'b0;
                    err_d   = 1'b1;
                    if (gnt_d_q) begin
                        ddone_d = 1'b1;
                        if (!mwrite_q)
                            drdata_d = '0;
                    end else begin
                        idone_d  = 1'b1;
                        irdata_d = '0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            gnt_d_q   <= 1'b0;
            starve_q  <= '0;
            tmo_q     <= '0;
            mreq_q    <= 1'b0;
            mwrite_q  <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            mbyteen_q <= '0;
            irdata_q  <= '0;
            drdata_q  <= '0;
            idone_q   <= 1'b0;
            ddone_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_d_q   <= gnt_d_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            mreq_q    <= mreq_d;
            mwrite_q  <= mwrite_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            mbyteen_q <= mbyteen_d;
            irdata_q  <= irdata_d;
            drdata_q  <= drdata_d;
            idone_q   <= idone_d;
            ddone_q   <= ddone_d;
            err_q     <= err_d;
        end
    end

    assign bus.MReq    = mreq_q;
    assign bus.MWrite  = mwrite_q;
    assign bus.MAddr   = maddr_q;
    assign bus.MWData  = mwdata_q;
    assign bus.MByteEn = mbyteen_q;
    assign bus.IRData  = irdata_q;
    assign bus.DRData  = drdata_q;
    assign bus.IDone   = idone_q;
    assign bus.DDone   = ddone_q;
    assign bus.Err     = err_q;
    assign bus.nStall  = ~((bus.IReq & ~idone_q) | (d_req & ~ddone_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed stimulus pushes expected grants/responses,
// independent monitors pop and compare whenever the DUT raises MReq or a Done pulse.
module tb_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        port;   // 0 = I, 1 = D
        logic [31:0] data;
        logic        err;
    } resp_t;

    typedef struct packed {
        logic [15:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  be;
    } grant_t;

    logic Clock;
    logic nReset;
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   last_idone_cyc = 0;
    int   last_ddone_cyc = 0;

    resp_t  exp_resp[$];
    grant_t exp_grant[$];

    bit mem_en   = 1'b1;
    int ack_wait = 0;
    int wcnt     = 0;
    logic mreq_prev = 1'b0;

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    mem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(2),
        .TIMEOUT(8)
    ) u_dut (
        .Clock(Clock),
        .nReset(nReset),
        .bus(bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial forever begin
        @(posedge Clock);
        cyc_n++;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'h2402_0005;
        return {16'hD00D, a};
    endfunction

    // Memory model: acknowledges after ack_wait idle cycles of MReq
    initial begin
        bus.MAck   = 1'b0;
        bus.MRData = '0;
        forever begin
            @(negedge Clock);
            if (bus.MReq && !bus.MAck && mem_en) begin
                if (wcnt == ack_wait) begin
                    bus.MAck   = 1'b1;
                    bus.MRData = mem_word(bus.MAddr);
                    wcnt       = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                bus.MAck = 1'b0;
                if (!bus.MReq) wcnt = 0;
            end
        end
    end

    // Response monitor
    initial forever begin
        resp_t r;
        @(negedge Clock);
        if (bus.IDone) last_idone_cyc = cyc_n;
        if (bus.DDone) last_ddone_cyc = cyc_n;
        if (bus.IDone || bus.DDone) begin
            if (exp_resp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got I=%0b D=%0b exp none", bus.IDone, bus.DDone);
            end else begin
                r = exp_resp.pop_front();
                chk("done_port", bus.DDone, r.port);
                chk("done_both", bus.IDone & bus.DDone, 0);
                chk("rdata", r.port ? bus.DRData : bus.IRData, r.data);
                chk("err", bus.Err, r.err);
            end
        end else begin
            chk("err_idle", bus.Err, 0);
        end
    end

    // Grant monitor: compares the memory request on each MReq rising edge
    initial forever begin
        grant_t g;
        @(negedge Clock);
        if (bus.MReq && !mreq_prev) begin
            if (exp_grant.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant got addr %0h exp none", bus.MAddr);
            end else begin
                g = exp_grant.pop_front();
                chk("grant_addr", bus.MAddr, g.addr);
                chk("grant_write", bus.MWrite, g.write);
                chk("grant_be", bus.MByteEn, g.be);
                if (g.write) chk("grant_wdata", bus.MWData, g.wdata);
            end
        end
        mreq_prev = bus.MReq;
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_done(input bit dport, input int budget);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (!(dport ? bus.DDone : bus.IDone) && n < budget);
        chk(dport ? "wait_ddone" : "wait_idone", dport ? bus.DDone : bus.IDone, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_resp.size() != 0 || exp_grant.size() != 0) && n < budget) begin
            @(negedge Clock);
            n++;
        end
        chk("drain_resp", exp_resp.size(), 0);
        chk("drain_grant", exp_grant.size(), 0);
        repeat (2) @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        nReset      = 1'b0;
        bus.IReq    = 1'b0;
        bus.IAddr   = '0;
        bus.DRead   = 1'b0;
        bus.DWrite  = 1'b0;
        bus.DAddr   = '0;
        bus.DWData  = '0;
        bus.DByteEn = '0;

        // Reset state
        repeat (3) @(negedge Clock);
        chk("rst_mreq", bus.MReq, 0);
        chk("rst_mwrite", bus.MWrite, 0);
        chk("rst_maddr", bus.MAddr, 0);
        chk("rst_mbyteen", bus.MByteEn, 0);
        chk("rst_irdata", bus.IRData, 0);
        chk("rst_drdata", bus.DRData, 0);
        chk("rst_nstall", bus.nStall, 1);
        nReset = 1'b1;

        // Single fetch, 0 waits
        cyc();
        bus.IReq  = 1'b1;
        bus.IAddr = 16'h0010;
        exp_grant.push_back('{16'h0010, 1'b0, 32'h0, 4'hF});
        exp_resp.push_back('{1'b0, 32'h2402_0005, 1'b0});
        @(negedge Clock);
        chk("t1_c0_mreq", bus.MReq, 0);
        chk("t1_c0_nstall", bus.nStall, 0);
        cyc();
        @(negedge Clock);
        chk("t1_c1_mreq", bus.MReq, 1);
        chk("t1_c1_nstall", bus.nStall, 0);
        cyc();
        @(negedge Clock);
        chk("t1_c2_idone", bus.IDone, 1);
        chk("t1_c2_nstall", bus.nStall, 1);
        cyc();
        bus.IReq = 1'b0;
        drain(50);

        // Simultaneous I and D: data first, fetch 3 cycles later
        cyc();
        bus.IReq  = 1'b1;
        bus.IAddr = 16'h0020;
        bus.DRead = 1'b1;
        bus.DAddr = 16'h0100;
        exp_grant.push_back('{16'h0100, 1'b0, 32'h0, 4'hF});
        exp_grant.push_back('{16'h0020, 1'b0, 32'h0, 4'hF});
        exp_resp.push_back('{1'b1, 32'hD00D_0100, 1'b0});
        exp_resp.push_back('{1'b0, 32'hD00D_0020, 1'b0});
        wait_done(1'b1, 20);
        cyc();
        bus.DRead = 1'b0;
        wait_done(1'b0, 20);
        chk("t2_idone_gap", last_idone_cyc - last_ddone_cyc, 3);
        cyc();
        bus.IReq = 1'b0;
        drain(50);

        // Starvation: STARVE_MAX=2 gives D, D, I, D, D, I
        nReset = 1'b0;
        @(negedge Clock);
        nReset = 1'b1;
        cyc();
        bus.IReq  = 1'b1;
        bus.IAddr = 16'h0030;
        bus.DRead = 1'b1;
        bus.DAddr = 16'h0200;
        for (int i = 0; i < 2; i++) begin
            exp_grant.push_back('{16'h0200, 1'b0, 32'h0, 4'hF});
            exp_grant.push_back('{16'h0200, 1'b0, 32'h0, 4'hF});
            exp_grant.push_back('{16'h0030, 1'b0, 32'h0, 4'hF});
            exp_resp.push_back('{1'b1, 32'hD00D_0200, 1'b0});
            exp_resp.push_back('{1'b1, 32'hD00D_0200, 1'b0});
            exp_resp.push_back('{1'b0, 32'hD00D_0030, 1'b0});
        end
        n = 0;
        for (int k = 0; k < 6; k++) begin
            int b = 0;
            do begin
                @(negedge Clock);
                b++;
            end while (!(bus.IDone || bus.DDone) && b < 20);
            if (bus.IDone || bus.DDone) n++;
        end
        chk("t3_done_count", n, 6);
        cyc();
        bus.IReq  = 1'b0;
        bus.DRead = 1'b0;
        drain(50);

        // Write with 2 wait states; DRData keeps the last load value
        ack_wait = 2;
        cyc();
        bus.DWrite  = 1'b1;
        bus.DAddr   = 16'h0300;
        bus.DWData  = 32'hCAFE_F00D;
        bus.DByteEn = 4'b0011;
        exp_grant.push_back('{16'h0300, 1'b1, 32'hCAFE_F00D, 4'b0011});
        exp_resp.push_back('{1'b1, 32'hD00D_0200, 1'b0});
        @(negedge Clock);
        for (int i = 1; i <= 3; i++) begin
            cyc();
            @(negedge Clock);
            chk("t4_mreq", bus.MReq, 1);
            chk("t4_mwrite", bus.MWrite, 1);
            chk("t4_mbyteen", bus.MByteEn, 4'b0011);
            chk("t4_mwdata", bus.MWData, 32'hCAFE_F00D);
        end
        cyc();
        @(negedge Clock);
        chk("t4_c4_ddone", bus.DDone, 1);
        chk("t4_c4_mreq", bus.MReq, 0);
        cyc();
        bus.DWrite = 1'b0;
        ack_wait   = 0;
        drain(50);

        // Timeout on a read: 8 BUSY cycles, then DDone with Err and zero data
        mem_en = 1'b0;
        cyc();
        bus.DRead = 1'b1;
        bus.DAddr = 16'h0400;
        exp_grant.push_back('{16'h0400, 1'b0, 32'h0, 4'hF});
        exp_resp.push_back('{1'b1, 32'h0, 1'b1});
        @(negedge Clock);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            @(negedge Clock);
            if (!bus.MReq) break;
            n++;
        end
        chk("t5_busy_cycles", n, 8);
        chk("t5_ddone", bus.DDone, 1);
        chk("t5_err", bus.Err, 1);
        chk("t5_drdata", bus.DRData, 0);
        cyc();
        bus.DRead = 1'b0;
        @(negedge Clock);
        chk("t5_err_clear", bus.Err, 0);
        chk("t5_idle_mreq", bus.MReq, 0);
        drain(50);

        // Reset during DBUSY: access abandoned, then re-arbitrated after release
        cyc();
        bus.DRead = 1'b1;
        bus.DAddr = 16'h0500;
        exp_grant.push_back('{16'h0500, 1'b0, 32'h0, 4'hF});
        @(negedge Clock);
        cyc();
        @(negedge Clock);
        chk("t6_mreq_busy", bus.MReq, 1);
        cyc();
        nReset = 1'b0;
        #1;
        chk("t6_mreq_async", bus.MReq, 0);
        chk("t6_no_ddone", bus.DDone, 0);
        repeat (2) @(negedge Clock);
        chk("t6_no_ddone_rst", bus.DDone, 0);
        mem_en = 1'b1;
        exp_grant.push_back('{16'h0500, 1'b0, 32'h0, 4'hF});
        exp_resp.push_back('{1'b1, 32'hD00D_0500, 1'b0});
        nReset = 1'b1;
        wait_done(1'b1, 20);
        cyc();
        bus.DRead = 1'b0;
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch requester (IF stage) and the load/store requester (MEM stage) of the 5-stage PROCESSOR pipeline. Arbitrates with data-over-instruction priority and an anti-starvation counter, and sequences the memory request/acknowledge handshake with a watchdog timeout. Drives the pipeline stall while any request is outstanding.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 32, data width; byte-enable width is DATA_W/8
STARVE_MAX, 4, consecutive data grants allowed while IReq is pending before the instruction port is forced
TIMEOUT, 64, cycles in a BUSY state without MAck before the access is aborted

Ports:
Clock  in  1  clock, rising edge
nReset  in  1  asynchronous, active-low reset
IReq  in  1  instruction fetch request, held until IDone
IAddr  in  ADDR_W  fetch address
IRData  out  DATA_W  fetched word, valid when IDone=1
IDone  out  1  one-cycle fetch-complete pulse
DRead  in  1  data load request, held until DDone
DWrite  in  1  data store request, held until DDone
DAddr  in  ADDR_W  data address
DWData  in  DATA_W  store data
DByteEn  in  DATA_W/8  store byte enables
DRData  out  DATA_W  load data, valid when DDone=1
DDone  out  1  one-cycle data-complete pulse
MReq  out  1  memory request, held until MAck
MWrite  out  1  1=write, 0=read
MAddr  out  ADDR_W  memory address
MWData  out  DATA_W  memory write data
MByteEn  out  DATA_W/8  memory byte enables (all ones on reads)
MRData  in  DATA_W  memory read data, valid in MAck cycle
MAck  in  1  memory acknowledge, one-cycle pulse
Err  out  1  timeout flag, valid with IDone/DDone
nStall  out  1  low while any request is pending and not completing this cycle

Behaviour:
- Reset: state IDLE; MReq, MWrite, IDone, DDone, Err = 0; MAddr, MWData, MByteEn, IRData, DRData = 0; starvation and timeout counters = 0. Reset takes effect immediately mid-access. MReq drops asynchronously and the access is abandoned without Done.
- FSM states: IDLE, IBUSY, DBUSY, RESP.
- IDLE arbitration, evaluated each cycle:
  - DReq = DRead|DWrite. DWrite wins if both are high, and the access is a write.
  - If DReq && !(IReq && starve==STARVE_MAX): grant D and go to DBUSY. starve increments (saturating) if IReq=1, else clears.
  - Else if IReq: grant I, go to IBUSY, starve clears.
  - Otherwise stay in IDLE.
  - On grant, register MReq=1 and register MAddr/MWrite/MWData/MByteEn from the granted port. These stay stable until the access leaves BUSY.
- IBUSY/DBUSY:
  - On MAck=1: capture MRData into IRData or DRData (write: DRData unchanged), drop MReq, go to RESP. Done pulses for the granted port, Err=0.
  - The timeout counter increments each BUSY cycle without MAck. If it reaches TIMEOUT-1 without MAck: drop MReq, go to RESP with Err=1. Read data for the granted port is forced to 0.
  - The timeout counter clears on entering BUSY.
- RESP: exactly one cycle. The granted port's Done=1, all registered data is valid. Next state is IDLE. No new grant is made in RESP.
  - A requester must drop Req in the cycle after Done, or present a new request.
  - Req high in IDLE after RESP is always treated as a new request.
- Latency:
  - Request high at cycle 0 in IDLE: MReq=1 at cycle 1.
  - MAck at cycle 1+W gives Done at cycle 2+W.
  - Minimum 3 cycles per access; back-to-back accesses every 3+W cycles.
- MAck outside BUSY is ignored.
- nStall is combinational: ~((IReq & ~IDone) | (DReq & ~DDone)).
- Err is cleared in every cycle that is not a RESP cycle.

Test Plan:
- IReq=1, IAddr=0x0010, MAck after 0 waits with MRData=0x2402_0005: MReq=1 at cycle 1 with MAddr=0x0010 and MWrite=0. IDone=1 at cycle 2 with IRData=0x2402_0005. nStall=0 in cycles 0-1, 1 in cycle 2.
- IReq and DRead both high at cycle 0: D is granted first (MAddr=DAddr). DDone follows, then I is granted from IDLE. IDone arrives 3 cycles after DDone with 0-wait memory.
- STARVE_MAX=2, IReq held, DRead re-asserted every access: grant order is D, D, I, D, D, I.
- DWrite=1, DWData=0xCAFE_F00D, DByteEn=4'b0011, 2 wait states: MWrite=1, MByteEn=0011, MWData=0xCAFE_F00D held for 3 cycles. DDone=1 at cycle 4, Err=0.
- TIMEOUT=8 with no MAck on a data read: MReq drops after 8 BUSY cycles. DDone=1, Err=1, DRData=0. Next cycle Err=0 and state is IDLE.
- nReset pulsed low during DBUSY: MReq=0 immediately, no DDone. After release, the held DRead is re-arbitrated and completes normally.
